// File: rtl/wb_port_arbiter_pkg.sv
// Shared register-file bus types and LU result FIFO entry layout for the
// writeback port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] RegAddrBus;
  typedef logic [REG_DATA_W-1:0] RegBus;

  localparam RegAddrBus NOPRegAddr   = '0;
  localparam RegBus     ZeroWord     = '0;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;

  // One buffered long-latency result; valid drops when a younger write kills it.
  typedef struct packed {
    logic      valid;
    RegAddrBus wd;
    RegBus     wdata;
  } lu_entry_t;

endpackage

// File: rtl/wb_lu_fifo.sv
// LU result FIFO: circular storage with kill-by-address, presenting its
// contents oldest-first so entries_o[0] is always the head.
module wb_lu_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  RegAddrBus             push_wd_i,
  input  RegBus                 push_wdata_i,
  input  logic                  pop_i,
  input  logic                  kill_i,
  input  RegAddrBus             kill_wd_i,
  output logic                  empty_o,
  output logic                  full_o,
  output lu_entry_t [DEPTH-1:0] entries_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  lu_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  store;

  // Results aimed at r0 are accepted from the LU but never occupy a slot.
  assign store = push_i && (push_wd_i != NOPRegAddr);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (kill_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (mem_q[PTR_W'(i)].wd == kill_wd_i) mem_d[PTR_W'(i)].valid = 1'b0;
      end
    end
    if (pop_i) begin
      mem_d[rptr_q].valid = 1'b0;
      rptr_d              = rptr_q + PTR_W'(1);
    end
    if (store) begin
      mem_d[wptr_q] = '{valid: 1'b1, wd: push_wd_i, wdata: push_wdata_i};
      wptr_d        = wptr_q + PTR_W'(1);
    end
    case ({store, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

  // Age-ordered view: index 0 is the head, higher indices are younger.
  always_comb begin
    entries_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entries_o[PTR_W'(i)] = mem_q[rptr_q + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between MEM/WB writeback and buffered LU results.
// Define WB_ARB_FWD_EN to enable forwarding lookup of pending LU results.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      wb_wreg,
  input  RegAddrBus wb_wd,
  input  RegBus     wb_wdata,
  input  logic      lu_valid,
  input  RegAddrBus lu_wd,
  input  RegBus     lu_wdata,
  output logic      lu_ready,
  output logic      rf_we,
  output RegAddrBus rf_waddr,
  output RegBus     rf_wdata,
  output logic      stallreq,
  input  RegAddrBus fwd_raddr1,
  input  RegAddrBus fwd_raddr2,
  output logic      fwd_hit1,
  output logic      fwd_hit2,
  output RegBus     fwd_data1,
  output RegBus     fwd_data2
);

  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  lu_entry_t [DEPTH-1:0] entries;
  lu_entry_t             head;
  logic                  empty, full, head_live, pop, kill, push;
  logic [STV_W-1:0]      starve_q, starve_d;

  assign head      = entries[0];
  assign head_live = !empty && head.valid;
  assign push      = lu_valid && lu_ready;
  assign kill      = wb_wreg && (wb_wd != NOPRegAddr);
  assign lu_ready  = !full;

  wb_lu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_wd_i    (lu_wd),
    .push_wdata_i (lu_wdata),
    .pop_i        (pop),
    .kill_i       (kill),
    .kill_wd_i    (wb_wd),
    .empty_o      (empty),
    .full_o       (full),
    .entries_o    (entries)
  );

  // Pipeline always wins the port; a killed head retires silently in any cycle.
  always_comb begin
    rf_we    = WriteDisable;
    rf_waddr = NOPRegAddr;
    rf_wdata = ZeroWord;
    pop      = 1'b0;
    if (wb_wreg) begin
      rf_we    = WriteEnable;
      rf_waddr = wb_wd;
      rf_wdata = wb_wdata;
    end else if (head_live) begin
      rf_we    = WriteEnable;
      rf_waddr = head.wd;
      rf_wdata = head.wdata;
      pop      = 1'b1;
    end
    if (!empty && !head.valid) pop = 1'b1;
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (head_live && wb_wreg && (starve_q != STV_W'(STARVE_MAX))) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  assign stallreq = (starve_q == STV_W'(STARVE_MAX)) || full;

`ifdef WB_ARB_FWD_EN
  // Later entries are younger, so the last match in the scan wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = ZeroWord;
    fwd_data2 = ZeroWord;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && (fwd_raddr1 != NOPRegAddr) && (entries[i].wd == fwd_raddr1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = entries[i].wdata;
      end
      if (entries[i].valid && (fwd_raddr2 != NOPRegAddr) && (entries[i].wd == fwd_raddr2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = entries[i].wdata;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_raddr1, fwd_raddr2, entries};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data1  = ZeroWord;
  assign fwd_data2  = ZeroWord;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table plus LU-write scoreboard,
// followed by forwarding and mid-stream reset sequences.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_wreg;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;
  logic        lu_valid;
  logic [4:0]  lu_wd;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stallreq;
  logic [4:0]  fwd_raddr1, fwd_raddr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;

  wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_wreg    (wb_wreg),
    .wb_wd      (wb_wd),
    .wb_wdata   (wb_wdata),
    .lu_valid   (lu_valid),
    .lu_wd      (lu_wd),
    .lu_wdata   (lu_wdata),
    .lu_ready   (lu_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .stallreq   (stallreq),
    .fwd_raddr1 (fwd_raddr1),
    .fwd_raddr2 (fwd_raddr2),
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        lu_valid;
    logic [4:0]  lu_wd;
    logic [31:0] lu_wdata;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_ready;
    logic        e_stall;
  } vec_t;

  typedef struct {
    logic [4:0]  wd;
    logic [31:0] wdata;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  function automatic vec_t mk(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                              input logic luv, input logic [4:0] lwd, input logic [31:0] ldata,
                              input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                              input logic erdy, input logic estl);
    vec_t v;
    v.wb_wreg  = wreg;
    v.wb_wd    = wd;
    v.wb_wdata = wdata;
    v.lu_valid = luv;
    v.lu_wd    = lwd;
    v.lu_wdata = ldata;
    v.e_we     = ewe;
    v.e_waddr  = ewa;
    v.e_wdata  = ewd;
    v.e_ready  = erdy;
    v.e_stall  = estl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, sample on the falling edge, update the scoreboard.
  task automatic drive_chk(input vec_t v, input string tag);
    sb_t e;
    wb_wreg  = v.wb_wreg;
    wb_wd    = v.wb_wd;
    wb_wdata = v.wb_wdata;
    lu_valid = v.lu_valid;
    lu_wd    = v.lu_wd;
    lu_wdata = v.lu_wdata;
    @(negedge clk);
    chk($sformatf("%s.rf_we", tag),    32'(rf_we),    32'(v.e_we));
    chk($sformatf("%s.rf_waddr", tag), 32'(rf_waddr), 32'(v.e_waddr));
    chk($sformatf("%s.rf_wdata", tag), rf_wdata,      v.e_wdata);
    chk($sformatf("%s.lu_ready", tag), 32'(lu_ready), 32'(v.e_ready));
    chk($sformatf("%s.stallreq", tag), 32'(stallreq), 32'(v.e_stall));
    if (rf_we && !v.wb_wreg) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL %s.sb_unexpected: LU write addr %0d data 0x%08h, none pending", tag, rf_waddr, rf_wdata);
      end else begin
        e = sb.pop_front();
        chk($sformatf("%s.sb_waddr", tag), 32'(rf_waddr), 32'(e.wd));
        chk($sformatf("%s.sb_wdata", tag), rf_wdata, e.wdata);
      end
    end
    if (v.wb_wreg && (v.wb_wd != 5'd0)) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].wd == v.wb_wd) sb.delete(i);
      end
    end
    if (v.lu_valid && v.e_ready && (v.lu_wd != 5'd0)) begin
      e.wd    = v.lu_wd;
      e.wdata = v.lu_wdata;
      sb.push_back(e);
    end
  endtask

  task automatic chk_fwd_idle(input string tag);
    chk($sformatf("%s.fwd_hit1", tag),  32'(fwd_hit1),  32'd0);
    chk($sformatf("%s.fwd_data1", tag), fwd_data1,      32'd0);
    chk($sformatf("%s.fwd_hit2", tag),  32'(fwd_hit2),  32'd0);
    chk($sformatf("%s.fwd_data2", tag), fwd_data2,      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    wb_wreg    = 1'b0;
    wb_wd      = 5'd0;
    wb_wdata   = 32'd0;
    lu_valid   = 1'b0;
    lu_wd      = 5'd0;
    lu_wdata   = 32'd0;
    fwd_raddr1 = 5'd5;
    fwd_raddr2 = 5'd7;
    tick();
    tick();
    drive_chk(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0), "reset");
    chk_fwd_idle("reset");
    tick();
    rst = 1'b0;

    // Single LU result into an idle port, then pipeline pass-through
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd12, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1234, 1'b1, 1'b0));
    // Starvation: pipeline holds the port 10 cycles with one LU entry pending
    for (int k = 0; k < 10; k++) begin
      vecs.push_back(mk(1'b1, 5'd3, 32'hA0 + 32'(k), (k == 0), (k == 0) ? 5'd7 : 5'd0,
                        (k == 0) ? 32'h77 : 32'd0, 1'b1, 5'd3, 32'hA0 + 32'(k), 1'b1, (k == 9)));
    end
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0));
    // Fill to full while busy; third result waits for the first drain
    vecs.push_back(mk(1'b1, 5'd3, 32'h300, 1'b1, 5'd10, 32'h100, 1'b1, 5'd3, 32'h300, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd3, 32'h301, 1'b1, 5'd11, 32'h101, 1'b1, 5'd3, 32'h301, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd3, 32'h302, 1'b1, 5'd12, 32'h102, 1'b1, 5'd3, 32'h302, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h102, 1'b1, 5'd10, 32'h100, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h102, 1'b1, 5'd11, 32'h101, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h102, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0));
    // WAW kill: pending r9 killed by pipeline r9; killed head pops while pipeline owns port
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h900, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd9, 32'h999, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h999, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd4, 32'h444, 1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 32'h444, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd4, 32'h445, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h445, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0));
    // r0 result is accepted but never stored: two later pushes just reach full
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd3, 32'h3, 1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 32'h3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd3, 32'h4, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h4, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive_chk(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Forwarding: two pending r4 results, youngest must be returned
    fwd_raddr1 = 5'd4;
    fwd_raddr2 = 5'd0;
    drive_chk(mk(1'b1, 5'd3, 32'h30, 1'b1, 5'd4, 32'h11, 1'b1, 5'd3, 32'h30, 1'b1, 1'b0), "fwd0");
    tick();
    drive_chk(mk(1'b1, 5'd3, 32'h31, 1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h31, 1'b1, 1'b0), "fwd1");
    tick();
    drive_chk(mk(1'b1, 5'd3, 32'h32, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h32, 1'b0, 1'b1), "fwd2");
`ifdef WB_ARB_FWD_EN
    chk("fwd2.fwd_hit1",  32'(fwd_hit1), 32'd1);
    chk("fwd2.fwd_data1", fwd_data1,     32'h22);
`else
    chk("fwd2.fwd_hit1",  32'(fwd_hit1), 32'd0);
    chk("fwd2.fwd_data1", fwd_data1,     32'd0);
`endif
    chk("fwd2.fwd_hit2",  32'(fwd_hit2), 32'd0);
    chk("fwd2.fwd_data2", fwd_data2,     32'd0);
    tick();

    // Reset with a full FIFO while the LU keeps lu_valid asserted
    rst      = 1'b1;
    wb_wreg  = 1'b0;
    wb_wd    = 5'd0;
    wb_wdata = 32'd0;
    lu_valid = 1'b1;
    lu_wd    = 5'd8;
    lu_wdata = 32'h88;
    tick();
    rst = 1'b0;
    sb.delete();
    drive_chk(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0), "post_rst");
    chk_fwd_idle("post_rst");
    tick();
    drive_chk(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88, 1'b1, 1'b0), "post_rst_drain");
    tick();
    drive_chk(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0), "post_rst_idle");
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single general-register-file write port between the in-order MEM/WB pipeline writeback and a long-latency unit (LU: divider, future multi-cycle ops). It sits between the MEM/WB pipeline register and the regfile write port. LU results are buffered in a small FIFO and drained into idle writeback cycles. When the pipeline hogs the port too long, the block requests a stall from the pipeline controller.

## Interface
- DEPTH, 2: LU result FIFO entries (power of two, ≥2)
- STARVE_MAX, 8: cycles a valid FIFO head may wait before stall request
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_wreg  in  1  pipeline writeback enable (from MEM/WB)
- wb_wd  in  5  pipeline destination register
- wb_wdata  in  32  pipeline write data
- lu_valid  in  1  LU result available
- lu_wd  in  5  LU destination register
- lu_wdata  in  32  LU result data
- lu_ready  out  1  FIFO can accept; equals !full
- rf_we  out  1  regfile write enable
- rf_waddr  out  5  regfile write address
- rf_wdata  out  32  regfile write data
- stallreq  out  1  stall request to pipeline controller
- fwd_raddr1, fwd_raddr2  in  5 each  decode-stage read addresses (FWD only)
- fwd_hit1, fwd_hit2  out  1 each  a valid FIFO entry targets the address
- fwd_data1, fwd_data2  out  32 each  data of the youngest matching entry

## Operation
- FIFO entry: {valid, wd[4:0], wdata[31:0]}, with circular read/write pointers and a count of log2(DEPTH)+1 bits.
- Push: lu_valid && lu_ready at a posedge. An entry with lu_wd==0 is accepted and then discarded; it is not stored.
- Port mux (combinational):
  - If wb_wreg is high, the port goes to the pipeline: rf_we=1, rf_waddr=wb_wd, rf_wdata=wb_wdata.
  - Otherwise, if the FIFO is non-empty and the head is valid, rf_* is driven from the head and the head pops at the posedge.
  - Otherwise rf_we=0, rf_waddr=0, rf_wdata=0.
- Killed head: a non-empty FIFO with head valid=0 pops in any cycle without writing. It may pop in the same cycle the pipeline owns the port.
- WAW kill: in a cycle where wb_wreg is high and wb_wd≠0, every FIFO entry with wd==wb_wd has valid cleared at the posedge. The pipeline write is architecturally younger.
- Starvation counter:
  - Increments each cycle that a valid head is blocked by wb_wreg.
  - Clears on pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- stallreq = (counter == STARVE_MAX) || full. It is registered-state derived only and holds until the head pops.
- Push and pop in the same cycle: both take effect; count is unchanged.
- A push is never blocked by a pop in the same cycle, except that lu_ready reflects only the registered full flag.

## Timing
- Pipeline write reaches rf_* with zero latency, in the same cycle as wb_*.
- LU result minimum latency is 1 cycle: accepted at edge N, written at cycle N+1 if the port is idle.
- lu_ready, stallreq and fwd_hit* depend only on registers plus fwd_raddr*; there is no comb path from lu_valid.
- Reset values:
  - count=0, pointers=0, all valid=0, counter=0.
  - lu_ready=1, stallreq=0, rf_we=0, rf_waddr=0, rf_wdata=0, fwd_hit*=0, fwd_data*=0.
- Reset mid-operation discards all FIFO contents. LU holding lu_valid across reset is accepted the cycle after reset deasserts.

## Configuration
- WB_ARB_FWD_EN defined: forwarding lookup is active.
  - fwd_hit is set when any valid entry matches a nonzero address.
  - fwd_data is the youngest match in FIFO order.
- Undefined: the fwd_* inputs are ignored, fwd_hit*=0 and fwd_data*=0. Decode must interlock on LU destinations by scoreboard.

## Structure
- Shared package/defines hold RegAddrBus (5), RegBus (32), NOPRegAddr, ZeroWord, WriteEnable/WriteDisable, and the entry field widths.
- Sub-module wb_lu_fifo holds the storage, pointers, count, kill-by-address and head outputs. The top holds the port mux, starvation counter and forwarding search.

## Test plan
- Idle pipeline, lu_valid one cycle with wd=5, data 0xDEADBEEF → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; FIFO empty after.
- wb_wreg held high 10 cycles (wd=3) with one LU entry (wd=7) → stallreq rises after 8 blocked cycles; entry written on the first cycle wb_wreg=0; stallreq falls the following cycle.
- Two LU pushes with the pipeline busy → full: lu_ready=0, stallreq=1; a third lu_valid is held and accepted after the first drain.
- LU entry wd=9 pending, pipeline writes wd=9 → entry killed, popped without a write; register 9 keeps the pipeline value.
- lu_wd=0 push → no regfile write ever, count stays 0.
- With WB_ARB_FWD_EN: entries wd=4/0x11, then wd=4/0x22 pending, fwd_raddr1=4 → fwd_hit1=1, fwd_data1=0x22; fwd_raddr2=0 → fwd_hit2=0. Reset asserted mid-stream → all outputs at reset values the next cycle.
